// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM state encoding and default parameters shared by the pc_gen slice
package pc_gen_pkg;
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
  localparam int DEF_INST_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between core control (master) and pc_gen (slave); misalign_err under PC_ALIGN_CHECK_EN
interface pc_gen_if #(parameter int XLEN = 32, parameter int CNT_WIDTH = 64);
  logic stall;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic halt_req;
  logic resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic pc_valid;
  logic halted;
  logic [CNT_WIDTH-1:0] fetch_count;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign_err;
  modport master (output stall, redirect_valid, redirect_target, trap_valid, trap_vector, halt_req, resume,
                  input pc, pc_plus4, pc_valid, halted, fetch_count, misalign_err);
  modport slave (input stall, redirect_valid, redirect_target, trap_valid, trap_vector, halt_req, resume,
                 output pc, pc_plus4, pc_valid, halted, fetch_count, misalign_err);
`else
  modport master (output stall, redirect_valid, redirect_target, trap_valid, trap_vector, halt_req, resume,
                  input pc, pc_plus4, pc_valid, halted, fetch_count);
  modport slave (input stall, redirect_valid, redirect_target, trap_valid, trap_vector, halt_req, resume,
                 output pc, pc_plus4, pc_valid, halted, fetch_count);
`endif
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: priority select of the next pc and advance flag; alignment check under PC_ALIGN_CHECK_EN
module pc_next_mux import pc_gen_pkg::*; #(
  parameter int XLEN = 32,
  parameter int INST_BYTES = DEF_INST_BYTES
) (
  input  state_t state,
  input  logic stall,
  input  logic halt_req,
  input  logic redirect_valid,
  input  logic trap_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] next_pc,
`ifdef PC_ALIGN_CHECK_EN
  output logic misalign,
`endif
  output logic advance
);
  logic run, live, bad;
  always_comb begin
    run = state == S_RUN;
    live = run || state == S_HALT;
    pc_plus = pc + XLEN'(INST_BYTES);
`ifdef PC_ALIGN_CHECK_EN
    bad = |(redirect_target & XLEN'(INST_BYTES - 1));
    misalign = run && !trap_valid && redirect_valid && bad;
`else
    bad = 1'b0;
`endif
    // a misaligned target falls back to the trap handler rather than being fetched
    next_pc = live && trap_valid ? trap_vector :
              run && redirect_valid ? (bad ? trap_vector : redirect_target) :
              run && !halt_req && !stall ? pc_plus : pc;
    advance = (live && trap_valid) || (run && (redirect_valid || (!halt_req && !stall)));
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with redirect/trap/stall, halt FSM and fetch counter; PC_ALIGN_CHECK_EN adds misalign_err
module pc_gen import pc_gen_pkg::*; #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int INST_BYTES = DEF_INST_BYTES,
  parameter int CNT_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  pc_gen_if.slave bus
);
  state_t state, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt, pc_plus;
  logic [CNT_WIDTH-1:0] cnt;
  logic advance;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign, mis_q;
`endif
  pc_next_mux #(.XLEN(XLEN), .INST_BYTES(INST_BYTES)) u_mux (
    .state(state),
    .stall(bus.stall),
    .halt_req(bus.halt_req),
    .redirect_valid(bus.redirect_valid),
    .trap_valid(bus.trap_valid),
    .pc(pc_q),
    .redirect_target(bus.redirect_target),
    .trap_vector(bus.trap_vector),
    .pc_plus(pc_plus),
    .next_pc(pc_nxt),
`ifdef PC_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .advance(advance)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_BOOT;
      pc_q <= RESET_VECTOR;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      pc_q <= pc_nxt;
      cnt <= cnt + CNT_WIDTH'(advance);
    end
  end
  // halt is only taken in a cycle free of trap/redirect
  always_comb begin
    state_nxt = state == S_BOOT ? S_RUN :
                state == S_RUN ? (!bus.trap_valid && !bus.redirect_valid && bus.halt_req ? S_HALT : S_RUN) :
                state == S_HALT ? (bus.trap_valid || bus.resume ? S_RUN : S_HALT) : S_BOOT;
  end
  always_comb begin
    bus.pc = pc_q;
    bus.pc_plus4 = pc_plus;
    bus.pc_valid = state == S_RUN;
    bus.halted = state == S_HALT;
    bus.fetch_count = cnt;
  end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) mis_q <= rst && misalign;
  assign bus.misalign_err = mis_q;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen with hand-computed expectations
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pc_gen_if #(.XLEN(32), .CNT_WIDTH(64)) bus ();
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INST_BYTES(4), .CNT_WIDTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic [31:0] p, input logic v, input logic h, input logic [63:0] c);
    chk({tag, ".pc"}, 64'(bus.pc), 64'(p));
    chk({tag, ".pc_valid"}, 64'(bus.pc_valid), 64'(v));
    chk({tag, ".halted"}, 64'(bus.halted), 64'(h));
    chk({tag, ".fetch_count"}, bus.fetch_count, c);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    bus.trap_valid = 0; bus.trap_vector = 0; bus.halt_req = 0; bus.resume = 0;
    step; step;
    chk_st("reset", 32'h0, 0, 0, 0);
    rst = 1;
    step; chk_st("boot", 32'h0, 1, 0, 0);
    step; chk_st("run1", 32'h4, 1, 0, 1);
    step; chk_st("run2", 32'h8, 1, 0, 2);
    step; chk_st("run3", 32'hC, 1, 0, 3);
    step; chk_st("run4", 32'h10, 1, 0, 4);
    bus.stall = 1; bus.redirect_valid = 1; bus.redirect_target = 32'h100;
    step; chk_st("redir_stall", 32'h100, 1, 0, 5);
    bus.redirect_valid = 0;
    step; chk_st("stall1", 32'h100, 1, 0, 5);
    step; chk_st("stall2", 32'h100, 1, 0, 5);
    bus.stall = 0; bus.trap_valid = 1; bus.trap_vector = 32'h80;
    bus.redirect_valid = 1; bus.redirect_target = 32'h200;
    step; chk_st("trap_pri", 32'h80, 1, 0, 6);
    bus.trap_valid = 0; bus.redirect_target = 32'h20;
    step; chk_st("redir20", 32'h20, 1, 0, 7);
    bus.redirect_valid = 0; bus.halt_req = 1;
    step; chk_st("halt", 32'h20, 0, 1, 7);
    bus.redirect_valid = 1; bus.redirect_target = 32'h300; bus.stall = 1;
    for (int i = 0; i < 5; i++) begin
      step; chk_st("halt_hold", 32'h20, 0, 1, 7);
    end
    bus.redirect_valid = 0; bus.stall = 0; bus.halt_req = 0; bus.resume = 1;
    step; chk_st("resume", 32'h20, 1, 0, 7);
    bus.resume = 0;
    step; chk_st("after_resume", 32'h24, 1, 0, 8);
    bus.halt_req = 1; bus.redirect_valid = 1; bus.redirect_target = 32'h40;
    step; chk_st("halt_vs_redir", 32'h40, 1, 0, 9);
    bus.redirect_valid = 0;
    step; chk_st("halt2", 32'h40, 0, 1, 9);
    bus.halt_req = 0; bus.trap_valid = 1; bus.trap_vector = 32'h80; bus.resume = 1;
    step; chk_st("halt_trap", 32'h80, 1, 0, 10);
    bus.trap_valid = 0; bus.resume = 0; bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFC;
    step; chk_st("wrap_pre", 32'hFFFF_FFFC, 1, 0, 11);
    chk("wrap_plus4", 64'(bus.pc_plus4), 64'h0);
    bus.redirect_valid = 0;
    step; chk_st("wrap", 32'h0, 1, 0, 12);
    step; chk_st("wrap_next", 32'h4, 1, 0, 13);
    bus.halt_req = 1;
    step; chk_st("halt3", 32'h4, 0, 1, 13);
    rst = 0;
    step; chk_st("mid_reset", 32'h0, 0, 0, 0);
    rst = 1; bus.halt_req = 0;
    step; chk_st("boot2", 32'h0, 1, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_idle", 64'(bus.misalign_err), 64'h0);
    bus.redirect_valid = 1; bus.redirect_target = 32'h102; bus.trap_vector = 32'h80;
    step; chk_st("misalign", 32'h80, 1, 0, 1);
    chk("mis_pulse", 64'(bus.misalign_err), 64'h1);
    bus.redirect_valid = 0;
    step; chk_st("misalign_after", 32'h84, 1, 0, 2);
    chk("mis_clear", 64'(bus.misalign_err), 64'h0);
`else
    step; chk_st("run_after_reset", 32'h4, 1, 0, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
